// File: rtl/restoring_divider_ctrl.sv
// restoring_divider_ctrl: sequential unsigned restoring divider controller.
// Drives an external WIDTH-bit subtractor (A + ~B + Bin) once per ITER cycle
// and builds quotient/remainder one bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips iteration and goes
// straight to DONE on the accepting edge.
module restoring_divider_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    output logic             sub_bin,
    input  logic [WIDTH-1:0] sub_d,
    input  logic             sub_bout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] shift_s;

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            m_q         <= m_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Next-state, iteration datapath and handshake outputs
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        m_d         = m_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        sub_a       = '0;
        sub_b       = '0;
        shift_s     = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_d     = divisor;
                    q_d     = dividend;
                    r_d     = '0;
                    count_d = CW'(WIDTH - 1);
                    dbz_d   = (divisor == '0);
                    state_d = ITER;
`ifdef DIV_ZERO_FAST_EN
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        state_d     = DONE;
                    end
`else
`endif
                end
            end
            ITER: begin
                sub_a = shift_s;
                sub_b = m_q;
                r_d   = sub_bout ? sub_d : shift_s;
                q_d   = {q_q[WIDTH-2:0], sub_bout};
                if (count_q == '0) begin
                    // Capture the final step's results directly, not the stale registers
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    state_d     = DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sub_bin     = 1'b1;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// tb_restoring_divider_ctrl: directed and exhaustive checks of the divider
// controller, with a behavioural ripple subtractor model (A + ~B + 1).
module tb_restoring_divider_ctrl;

    localparam int W = 4;
`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_EDGES = 1;
`else
    localparam int DZ_EDGES = W + 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] sub_a;
    logic [W-1:0] sub_b;
    logic         sub_bin;
    logic [W-1:0] sub_d;
    logic         sub_bout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total;
    int bad;

    restoring_divider_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .sub_bin     (sub_bin),
        .sub_d       (sub_d),
        .sub_bout    (sub_bout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // External subtractor: A + ~B + Bin, carry-out means no borrow
    logic [W:0] sub_sum;
    always_comb begin
        sub_sum  = {1'b0, sub_a} + {1'b0, ~sub_b} + {{W{1'b0}}, sub_bin};
        sub_d    = sub_sum[W-1:0];
        sub_bout = sub_sum[W];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and let the next edge accept them; returns at edge+1
    task automatic start(input int n, input int m);
        chk("in_ready_before_accept", int'(in_ready), 1);
        dividend = W'(n);
        divisor  = W'(m);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
    endtask

    // Count edges (accepting edge = 1) until out_valid; subb_exp < 0 skips sub_b checks
    task automatic wait_result(input int subb_exp, output int edges);
        edges = 1;
        while (!out_valid && edges < 20) begin
            chk("sub_bin_tied", int'(sub_bin), 1);
            if (subb_exp >= 0) chk("sub_b_iter", int'(sub_b), subb_exp);
            tick();
            edges++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    int edges;
    int eq, er, ez;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        chk("rst_sub_a", int'(sub_a), 0);
        chk("rst_sub_b", int'(sub_b), 0);
        chk("rst_sub_bin", int'(sub_bin), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // 13 / 3
        start(13, 3);
        chk("t1_in_ready_busy", int'(in_ready), 0);
        chk("t1_first_sub_a", int'(sub_a), 1);
        chk("t1_first_sub_b", int'(sub_b), 3);
        wait_result(-1, edges);
        chk("t1_latency", edges, W + 1);
        chk("t1_quotient", int'(quotient), 4);
        chk("t1_remainder", int'(remainder), 1);
        chk("t1_dbz", int'(div_by_zero), 0);
        chk("t1_in_ready_done", int'(in_ready), 0);
        tick();
        chk("t1_out_valid_drop", int'(out_valid), 0);
        chk("t1_in_ready_after", int'(in_ready), 1);

        // 15 / 1 then 2 / 9 back to back
        start(15, 1);
        wait_result(1, edges);
        chk("t2a_quotient", int'(quotient), 15);
        chk("t2a_remainder", int'(remainder), 0);
        tick();
        start(2, 9);
        wait_result(9, edges);
        chk("t2b_quotient", int'(quotient), 0);
        chk("t2b_remainder", int'(remainder), 2);
        chk("t2b_dbz", int'(div_by_zero), 0);
        tick();

        // 7 / 0
        start(7, 0);
        wait_result(0, edges);
        chk("t3_latency", edges, DZ_EDGES);
        chk("t3_quotient", int'(quotient), 15);
        chk("t3_remainder", int'(remainder), 7);
        chk("t3_dbz", int'(div_by_zero), 1);
        tick();

        // 9 / 4 with result back-pressure
        out_ready = 1'b0;
        start(9, 4);
        wait_result(4, edges);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", int'(out_valid), 1);
            chk("t4_hold_quotient", int'(quotient), 2);
            chk("t4_hold_remainder", int'(remainder), 1);
            chk("t4_hold_in_ready", int'(in_ready), 0);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        chk("t4_release_valid", int'(out_valid), 0);
        chk("t4_release_in_ready", int'(in_ready), 1);

        // Reset during the second ITER cycle of 14 / 5
        start(14, 5);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_in_ready", int'(in_ready), 1);
        chk("t5_rst_quotient", int'(quotient), 0);
        chk("t5_rst_remainder", int'(remainder), 0);
        chk("t5_rst_sub_a", int'(sub_a), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_no_stale_valid", int'(out_valid), 0);
        start(14, 5);
        wait_result(5, edges);
        chk("t5_quotient", int'(quotient), 2);
        chk("t5_remainder", int'(remainder), 4);
        tick();

        // Exhaustive sweep against a reference model
        for (int n = 0; n < 16; n++) begin
            for (int m = 0; m < 16; m++) begin
                if (m == 0) begin
                    eq = 15; er = n; ez = 1;
                end else begin
                    eq = n / m; er = n % m; ez = 0;
                end
                start(n, m);
                wait_result(-1, edges);
                chk("sweep_latency", edges, (m == 0) ? DZ_EDGES : W + 1);
                chk("sweep_quotient", int'(quotient), eq);
                chk("sweep_remainder", int'(remainder), er);
                chk("sweep_dbz", int'(div_by_zero), ez);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/restoring_divider_ctrl.md
Name: restoring_divider_ctrl

Overview:
- Sequential unsigned restoring divider controller. Drives an external WIDTH-bit ripple subtractor stage (A - B computed as A + ~B + Bin) once per clock.
- Consumes the subtractor's difference and borrow-out to build quotient and remainder, one bit per cycle.
- Sits directly upstream/downstream of the subtractor: supplies its A/B/Bin operands and registers its D/Bout results.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 4, operand, quotient, remainder and subtractor width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept operands
- dividend  input  WIDTH  unsigned N
- divisor  input  WIDTH  unsigned M
- sub_a  output  WIDTH  subtractor A operand
- sub_b  output  WIDTH  subtractor B operand (the subtractor complements it internally)
- sub_bin  output  1  subtractor Bin, tied 1
- sub_d  input  WIDTH  subtractor difference
- sub_bout  input  1  subtractor carry-out; 1 = no borrow (sub_a >= sub_b)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  N / M
- remainder  output  WIDTH  N mod M
- div_by_zero  output  1  divisor was 0 for this result

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0.
  - quotient, remainder, div_by_zero, internal R, Q, M, count all 0.
  - sub_a=0, sub_b=0.
- States: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1; sub_a=0, sub_b=0.
  - On in_valid & in_ready edge: latch M=divisor, Q=dividend, R=0, count=WIDTH-1, div_by_zero=(divisor==0); go to ITER.
- ITER:
  - in_ready=0.
  - Combinational shifted value S = {R[WIDTH-2:0], Q[WIDTH-1]}; sub_a=S, sub_b=M.
  - Each edge: if sub_bout=1 then R<=sub_d, else R<=S. Q<={Q[WIDTH-2:0], sub_bout}.
  - If count==0, go to DONE; else count<=count-1.
  - Exactly WIDTH ITER cycles.
  - S never exceeds 2^WIDTH-1 (R < M and S <= top bits of N), so a WIDTH-bit subtractor is sufficient and no overflow bit exists.
- Entry to DONE registers quotient=Q and remainder=R.
- DONE:
  - out_valid=1, in_ready=0; outputs held stable until out_ready.
  - On out_valid & out_ready edge: out_valid<=0, go to IDLE.
  - No same-cycle accept of new operands (in_ready=0 in DONE).
- Latency: out_valid rises WIDTH+1 edges after the accepting edge.
  - Throughput: one division per WIDTH+2 cycles with out_ready held high.
- Divisor 0 with normal iteration: every step has sub_bout=1 and sub_d=S, giving quotient=all ones and remainder=dividend, with div_by_zero=1.
- Operand inputs are ignored outside the IDLE accept edge.
- in_valid while busy is ignored, not queued.
- out_ready while not out_valid has no effect.
- Reset asserted mid-ITER or mid-DONE: immediate return to reset values; the in-flight result is discarded and no out_valid is produced.
- sub_bin=1 constantly in all states.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined: if divisor==0 at the accept edge, skip ITER. On the next edge enter DONE with quotient=all ones, remainder=dividend, div_by_zero=1. out_valid rises 1 edge after accept, and sub_a/sub_b stay 0 throughout.
- Undefined: divisor 0 iterates the normal WIDTH cycles, with identical result values and flag.

Test Plan:
- 13/3, out_ready=1 -> after 5 edges: out_valid=1, quotient=4, remainder=1, div_by_zero=0; in_ready=1 the cycle after the handshake.
- 15/1, then 2/9 back-to-back -> quotient=15, remainder=0; then quotient=0, remainder=2; during 15/1 ITER, sub_b=1 every cycle.
- 7/0 -> quotient=15, remainder=7, div_by_zero=1. out_valid after 5 edges without DIV_ZERO_FAST_EN, after 1 edge with it.
- 9/4 with out_ready=0 for 10 cycles -> out_valid stays 1, quotient=2 and remainder=1 stable, in_ready=0; releases on the first out_ready=1 edge.
- Start 14/5, pulse rst_n low during the 2nd ITER cycle -> out_valid=0, in_ready=1, outputs 0; a new 14/5 then yields quotient=2, remainder=4.
- Exhaustive sweep of all 256 (N,M) pairs against a reference model, with the bench subtractor model computing A+~B+1 -> all quotient/remainder/flag values match.
